// File: rtl/register_memory.sv
// Register file for the 32-bit MIPS datapath: 32 x 32-bit registers, two asynchronous reads, two synchronous writes.
// Register 0 always reads as zero. When both ports write the same address in one cycle, port 2 wins.
module register_memory #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic [ADDR_W-1:0] WriteReg1,
  input  logic [ADDR_W-1:0] WriteReg2,
  input  logic [DATA_W-1:0] WriteData1,
  input  logic [DATA_W-1:0] WriteData2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic [1:0]        RegWrite_signal
);

  localparam int REG_N = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [REG_N];
  logic [DATA_W-1:0] regs_d [REG_N];
  logic              we1_s;
  logic              we2_s;

  // Qualify write enables; if() takes the else branch on X/Z, so unknown enables never write
  always_comb begin
    we1_s = 1'b0;
    we2_s = 1'b0;
    if (RegWrite_signal[1]) begin
      we1_s = 1'b1;
    end else begin
      we1_s = 1'b0;
    end
    if (RegWrite_signal[0]) begin
      we2_s = 1'b1;
    end else begin
      we2_s = 1'b0;
    end
  end

  // Next-state per register: port 2 is checked first so it wins a same-address collision
  always_comb begin
    for (int i = 0; i < REG_N; i++) begin
      regs_d[i] = regs_q[i];
    end
    for (int i = 1; i < REG_N; i++) begin
      if (we2_s && (WriteReg2 == ADDR_W'(i))) begin
        regs_d[i] = WriteData2;
      end else if (we1_s && (WriteReg1 == ADDR_W'(i))) begin
        regs_d[i] = WriteData1;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
    regs_d[0] = {DATA_W{1'b0}};
  end

  // Register array update; synchronous reset overrides any write in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < REG_N; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Combinational reads with no bypass; address 0 is forced to zero
  always_comb begin
    ReadData1 = {DATA_W{1'b0}};
    ReadData2 = {DATA_W{1'b0}};
    if (ReadReg1 == {ADDR_W{1'b0}}) begin
      ReadData1 = {DATA_W{1'b0}};
    end else begin
      ReadData1 = regs_q[ReadReg1];
    end
    if (ReadReg2 == {ADDR_W{1'b0}}) begin
      ReadData2 = {DATA_W{1'b0}};
    end else begin
      ReadData2 = regs_q[ReadReg2];
    end
  end

endmodule

// File: tb/tb_register_memory.sv
// Directed self-checking bench for register_memory: each task drives one scenario and checks inline.
module tb_register_memory;

  logic        clk;
  logic        rst;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [4:0]  WriteReg1;
  logic [4:0]  WriteReg2;
  logic [31:0] WriteData1;
  logic [31:0] WriteData2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [1:0]  RegWrite_signal;

  int errors;
  int checks;

  register_memory #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .ReadReg1(ReadReg1),
    .ReadReg2(ReadReg2),
    .WriteReg1(WriteReg1),
    .WriteReg2(WriteReg2),
    .WriteData1(WriteData1),
    .WriteData2(WriteData2),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2),
    .RegWrite_signal(RegWrite_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [1:0] en, input logic [4:0] a1, input logic [31:0] d1,
                             input logic [4:0] a2, input logic [31:0] d2);
    RegWrite_signal = en;
    WriteReg1 = a1;
    WriteData1 = d1;
    WriteReg2 = a2;
    WriteData2 = d2;
  endtask

  task automatic idle();
    drive_write(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    ReadReg1 = 5'd5;
    ReadReg2 = 5'd31;
    #1;
    checks++;
    if (ReadData1 !== 32'd0) begin errors++; $display("FAIL reset_r5 got=%h exp=%h", ReadData1, 32'd0); end
    checks++;
    if (ReadData2 !== 32'd0) begin errors++; $display("FAIL reset_r31 got=%h exp=%h", ReadData2, 32'd0); end
    drive_write(2'b10, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
    tick();
    idle();
    #1;
    checks++;
    if (ReadData1 !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_r5 got=%h exp=%h", ReadData1, 32'hDEADBEEF); end
    rst = 1'b1;
    drive_write(2'b11, 5'd6, 32'h12345678, 5'd7, 32'h0BADF00D);
    tick();
    rst = 1'b0;
    idle();
    ReadReg2 = 5'd6;
    #1;
    checks++;
    if (ReadData1 !== 32'd0) begin errors++; $display("FAIL reset_clears_r5 got=%h exp=%h", ReadData1, 32'd0); end
    checks++;
    if (ReadData2 !== 32'd0) begin errors++; $display("FAIL reset_overrides_write got=%h exp=%h", ReadData2, 32'd0); end
  endtask

  task automatic test_port1_only();
    drive_write(2'b10, 5'd10, 32'd14, 5'd10, 32'd99);
    tick();
    idle();
    ReadReg1 = 5'd10;
    #1;
    checks++;
    if (ReadData1 !== 32'd14) begin errors++; $display("FAIL port1_only got=%0d exp=%0d", ReadData1, 14); end
  endtask

  task automatic test_port2_only();
    drive_write(2'b01, 5'd20, 32'd555, 5'd20, 32'd66);
    tick();
    idle();
    ReadReg2 = 5'd20;
    #1;
    checks++;
    if (ReadData2 !== 32'd66) begin errors++; $display("FAIL port2_only got=%0d exp=%0d", ReadData2, 66); end
  endtask

  task automatic test_dual_write();
    drive_write(2'b11, 5'd11, 32'd14, 5'd12, 32'd7);
    tick();
    idle();
    ReadReg1 = 5'd11;
    ReadReg2 = 5'd12;
    #1;
    checks++;
    if (ReadData1 !== 32'd14) begin errors++; $display("FAIL dual_r11 got=%0d exp=%0d", ReadData1, 14); end
    checks++;
    if (ReadData2 !== 32'd7) begin errors++; $display("FAIL dual_r12 got=%0d exp=%0d", ReadData2, 7); end
  endtask

  task automatic test_collision();
    drive_write(2'b11, 5'd13, 32'd1, 5'd13, 32'd2);
    tick();
    idle();
    ReadReg1 = 5'd13;
    #1;
    checks++;
    if (ReadData1 !== 32'd2) begin errors++; $display("FAIL collision_r13 got=%0d exp=%0d", ReadData1, 2); end
  endtask

  task automatic test_reg0();
    drive_write(2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hA5A5A5A5);
    tick();
    idle();
    ReadReg1 = 5'd0;
    ReadReg2 = 5'd0;
    #1;
    checks++;
    if (ReadData1 !== 32'd0) begin errors++; $display("FAIL reg0_port1 got=%h exp=%h", ReadData1, 32'd0); end
    checks++;
    if (ReadData2 !== 32'd0) begin errors++; $display("FAIL reg0_port2 got=%h exp=%h", ReadData2, 32'd0); end
  endtask

  task automatic test_read_during_write();
    drive_write(2'b10, 5'd4, 32'd3, 5'd0, 32'd0);
    tick();
    ReadReg2 = 5'd4;
    drive_write(2'b01, 5'd0, 32'd0, 5'd4, 32'd9);
    #2;
    checks++;
    if (ReadData2 !== 32'd3) begin errors++; $display("FAIL rdw_before_edge got=%0d exp=%0d", ReadData2, 3); end
    tick();
    idle();
    #1;
    checks++;
    if (ReadData2 !== 32'd9) begin errors++; $display("FAIL rdw_after_edge got=%0d exp=%0d", ReadData2, 9); end
  endtask

  task automatic test_disabled_and_x();
    drive_write(2'b00, 5'd4, 32'd55, 5'd4, 32'd56);
    tick();
    ReadReg1 = 5'd4;
    #1;
    checks++;
    if (ReadData1 !== 32'd9) begin errors++; $display("FAIL disabled_write got=%0d exp=%0d", ReadData1, 9); end
    drive_write(2'bxx, 5'd4, 32'd77, 5'd4, 32'd78);
    tick();
    idle();
    #1;
    checks++;
    if (ReadData1 !== 32'd9) begin errors++; $display("FAIL x_enable got=%0d exp=%0d", ReadData1, 9); end
  endtask

  task automatic test_back_to_back();
    drive_write(2'b11, 5'd30, 32'h11111111, 5'd31, 32'h22222222);
    tick();
    drive_write(2'b11, 5'd31, 32'h33333333, 5'd29, 32'h44444444);
    tick();
    idle();
    ReadReg1 = 5'd30;
    ReadReg2 = 5'd31;
    #1;
    checks++;
    if (ReadData1 !== 32'h11111111) begin errors++; $display("FAIL b2b_r30 got=%h exp=%h", ReadData1, 32'h11111111); end
    checks++;
    if (ReadData2 !== 32'h33333333) begin errors++; $display("FAIL b2b_r31 got=%h exp=%h", ReadData2, 32'h33333333); end
    ReadReg1 = 5'd29;
    ReadReg2 = 5'd10;
    #1;
    checks++;
    if (ReadData1 !== 32'h44444444) begin errors++; $display("FAIL b2b_r29 got=%h exp=%h", ReadData1, 32'h44444444); end
    checks++;
    if (ReadData2 !== 32'd14) begin errors++; $display("FAIL retain_r10 got=%0d exp=%0d", ReadData2, 14); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    ReadReg1 = 5'd0;
    ReadReg2 = 5'd0;
    idle();
    test_reset();
    test_port1_only();
    test_port2_only();
    test_dual_write();
    test_collision();
    test_reg0();
    test_read_during_write();
    test_disabled_and_x();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
